// File: rtl/exponent_add_if.sv
// -----------------------------------------------------------------------------
// exponent_add_if
// Bundles the operand/result signals of the exponent_add pipeline.
//   master : the producer/consumer around the block (drives in_valid, stall,
//            A, B; observes the result fields)
//   slave  : the exponent_add block itself
// Signals:
//   in_valid  operand pair on A/B is valid this cycle
//   stall     downstream hold, freezes the whole pipeline
//   A, B      IEEE-754 single-precision operands
//   out_valid result fields valid
//   Ez_add    10-bit two's-complement biased exponent sum Ea+Eb-BIAS
//   Sz        result sign
//   Ma, Mb    24-bit mantissas with hidden bit
//   is_zero, is_inf, is_nan  special-result flags
// -----------------------------------------------------------------------------
interface exponent_add_if;
    logic        in_valid;
    logic        stall;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [9:0]  Ez_add;
    logic        Sz;
    logic [23:0] Ma;
    logic [23:0] Mb;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;

    modport master (
        output in_valid, stall, A, B,
        input  out_valid, Ez_add, Sz, Ma, Mb, is_zero, is_inf, is_nan
    );

    modport slave (
        input  in_valid, stall, A, B,
        output out_valid, Ez_add, Sz, Ma, Mb, is_zero, is_inf, is_nan
    );
endinterface

// File: rtl/exponent_add.sv
// -----------------------------------------------------------------------------
// exponent_add
// Two-stage pipeline that prepares the exponent/sign/mantissa fields for a
// single-precision multiply. Stage 1 registers the operand fields and a
// per-operand class (zero/denormal, inf, NaN, normal). Stage 2 decodes the
// special result, computes Ea+Eb-BIAS in 10-bit two's complement and emits
// mantissas with the hidden bit. A stall holds every register.
// Ports:
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset, clears all registers
//   bus   exponent_add_if.slave (operands in, result fields out)
// Parameters:
//   BIAS  exponent bias subtracted from the exponent sum (default 127)
// -----------------------------------------------------------------------------
module exponent_add #(
    parameter int BIAS = 127
) (
    input  logic CLK,
    input  logic RST,
    exponent_add_if.slave bus
);

    localparam logic [9:0] BIAS_W = 10'(BIAS);

    // Operand class encoding: {nan, inf, zero}; all clear means normal.
    localparam logic [2:0] CLS_NORMAL = 3'b000;
    localparam logic [2:0] CLS_ZERO   = 3'b001;
    localparam logic [2:0] CLS_INF    = 3'b010;
    localparam logic [2:0] CLS_NAN    = 3'b100;

    // Classify one operand; denormals share the zero class (flushed).
    function automatic logic [2:0] classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
        logic [2:0] cls;
        if (exp_f == 8'h00) begin
            cls = CLS_ZERO;
        end else if (exp_f == 8'hFF) begin
            if (frac_f != 23'd0) begin
                cls = CLS_NAN;
            end else begin
                cls = CLS_INF;
            end
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

    // ---------------- stage 1 registers ----------------
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sa_q,    s1_sa_d;
    logic        s1_sb_q,    s1_sb_d;
    logic [7:0]  s1_ea_q,    s1_ea_d;
    logic [7:0]  s1_eb_q,    s1_eb_d;
    logic [22:0] s1_fa_q,    s1_fa_d;
    logic [22:0] s1_fb_q,    s1_fb_d;
    logic [2:0]  s1_cls_a_q, s1_cls_a_d;
    logic [2:0]  s1_cls_b_q, s1_cls_b_d;

    // ---------------- stage 2 registers (block outputs) ----------------
    logic        s2_valid_q, s2_valid_d;
    logic        s2_sz_q,    s2_sz_d;
    logic [9:0]  s2_ez_q,    s2_ez_d;
    logic [23:0] s2_ma_q,    s2_ma_d;
    logic [23:0] s2_mb_q,    s2_mb_d;
    logic        s2_zero_q,  s2_zero_d;
    logic        s2_inf_q,   s2_inf_d;
    logic        s2_nan_q,   s2_nan_d;

    // ---------------- stage 2 decode ----------------
    logic        nan_s;
    logic        inf_s;
    logic        zero_s;
    logic        special_s;
    logic [9:0]  ez_sum_s;

    // Special-result priority decode and exponent sum from stage 1 fields.
    always_comb begin
        // inf x zero is undefined, so it joins the NaN case
        nan_s     = s1_cls_a_q[2] | s1_cls_b_q[2]
                  | (s1_cls_a_q[1] & s1_cls_b_q[0])
                  | (s1_cls_a_q[0] & s1_cls_b_q[1]);
        inf_s     = ~nan_s & (s1_cls_a_q[1] | s1_cls_b_q[1]);
        zero_s    = ~nan_s & ~inf_s & (s1_cls_a_q[0] | s1_cls_b_q[0]);
        special_s = nan_s | inf_s | zero_s;
        // 10 bits hold -125..381 without wrap for normal operands
        ez_sum_s  = {2'b00, s1_ea_q} + {2'b00, s1_eb_q} - BIAS_W;
    end

    // Next-state for both stages; a stall holds every register.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sa_d    = s1_sa_q;
        s1_sb_d    = s1_sb_q;
        s1_ea_d    = s1_ea_q;
        s1_eb_d    = s1_eb_q;
        s1_fa_d    = s1_fa_q;
        s1_fb_d    = s1_fb_q;
        s1_cls_a_d = s1_cls_a_q;
        s1_cls_b_d = s1_cls_b_q;
        s2_valid_d = s2_valid_q;
        s2_sz_d    = s2_sz_q;
        s2_ez_d    = s2_ez_q;
        s2_ma_d    = s2_ma_q;
        s2_mb_d    = s2_mb_q;
        s2_zero_d  = s2_zero_q;
        s2_inf_d   = s2_inf_q;
        s2_nan_d   = s2_nan_q;
        if (bus.stall) begin
            s1_valid_d = s1_valid_q;
            s2_valid_d = s2_valid_q;
        end else begin
            // Fields are captured every cycle so bubble data is deterministic.
            s1_valid_d = bus.in_valid;
            s1_sa_d    = bus.A[31];
            s1_sb_d    = bus.B[31];
            s1_ea_d    = bus.A[30:23];
            s1_eb_d    = bus.B[30:23];
            s1_fa_d    = bus.A[22:0];
            s1_fb_d    = bus.B[22:0];
            s1_cls_a_d = classify(bus.A[30:23], bus.A[22:0]);
            s1_cls_b_d = classify(bus.B[30:23], bus.B[22:0]);

            s2_valid_d = s1_valid_q;
            s2_sz_d    = s1_sa_q ^ s1_sb_q;
            s2_nan_d   = nan_s;
            s2_inf_d   = inf_s;
            s2_zero_d  = zero_s;
            if (special_s) begin
                // No special case leaves a meaningful exponent or mantissa.
                s2_ez_d = 10'd0;
                s2_ma_d = 24'd0;
                s2_mb_d = 24'd0;
            end else begin
                s2_ez_d = ez_sum_s;
                s2_ma_d = {1'b1, s1_fa_q};
                s2_mb_d = {1'b1, s1_fb_q};
            end
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_sa_q    <= 1'b0;
            s1_sb_q    <= 1'b0;
            s1_ea_q    <= 8'd0;
            s1_eb_q    <= 8'd0;
            s1_fa_q    <= 23'd0;
            s1_fb_q    <= 23'd0;
            s1_cls_a_q <= 3'd0;
            s1_cls_b_q <= 3'd0;
            s2_valid_q <= 1'b0;
            s2_sz_q    <= 1'b0;
            s2_ez_q    <= 10'd0;
            s2_ma_q    <= 24'd0;
            s2_mb_q    <= 24'd0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_nan_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sa_q    <= s1_sa_d;
            s1_sb_q    <= s1_sb_d;
            s1_ea_q    <= s1_ea_d;
            s1_eb_q    <= s1_eb_d;
            s1_fa_q    <= s1_fa_d;
            s1_fb_q    <= s1_fb_d;
            s1_cls_a_q <= s1_cls_a_d;
            s1_cls_b_q <= s1_cls_b_d;
            s2_valid_q <= s2_valid_d;
            s2_sz_q    <= s2_sz_d;
            s2_ez_q    <= s2_ez_d;
            s2_ma_q    <= s2_ma_d;
            s2_mb_q    <= s2_mb_d;
            s2_zero_q  <= s2_zero_d;
            s2_inf_q   <= s2_inf_d;
            s2_nan_q   <= s2_nan_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.Sz        = s2_sz_q;
    assign bus.Ez_add    = s2_ez_q;
    assign bus.Ma        = s2_ma_q;
    assign bus.Mb        = s2_mb_q;
    assign bus.is_zero   = s2_zero_q;
    assign bus.is_inf    = s2_inf_q;
    assign bus.is_nan    = s2_nan_q;

endmodule

// File: tb/tb_exponent_add.sv
// -----------------------------------------------------------------------------
// tb_exponent_add
// Self-checking bench for exponent_add: directed cases, a stalled stream,
// a mid-flight reset and a randomized run, compared against a reference
// model derived from the IEEE-754 field rules.
// -----------------------------------------------------------------------------
module tb_exponent_add;

    localparam int BIAS = 127;

    typedef struct packed {
        logic        v;
        logic        sz;
        logic [9:0]  ez;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        z;
        logic        i;
        logic        n;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    res_t pipe0;
    res_t pipe1;
    res_t prev_obs;

    exponent_add_if ifc ();

    exponent_add #(.BIAS(BIAS)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result of one operand pair from the field rules.
    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int   ea, eb, e;
        bit   za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        r    = '0;
        r.v  = 1'b1;
        r.sz = a[31] ^ b[31];
        r.n  = na || nb || (ia && zb) || (za && ib);
        r.i  = !r.n && (ia || ib);
        r.z  = !r.n && !r.i && (za || zb);
        if (!(r.n || r.i || r.z)) begin
            e    = ea + eb - BIAS;
            r.ez = e[9:0];
            r.ma = {1'b1, a[22:0]};
            r.mb = {1'b1, b[22:0]};
        end
        return r;
    endfunction

    function automatic res_t get_obs();
        res_t o;
        o.v  = ifc.out_valid;
        o.sz = ifc.Sz;
        o.ez = ifc.Ez_add;
        o.ma = ifc.Ma;
        o.mb = ifc.Mb;
        o.z  = ifc.is_zero;
        o.i  = ifc.is_inf;
        o.n  = ifc.is_nan;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, check after.
    task automatic step(input logic v, input logic st, input logic [31:0] a, input logic [31:0] b);
        res_t o;
        @(negedge clk);
        ifc.in_valid = v;
        ifc.stall    = st;
        ifc.A        = a;
        ifc.B        = b;
        @(posedge clk);
        if (!st) begin
            pipe1 = pipe0;
            pipe0 = v ? ref_model(a, b) : '0;
        end
        #1;
        o = get_obs();
        chk("out_valid", 63'(o.v), 63'(pipe1.v));
        if (pipe1.v) chk("result", o, pipe1);
        if (st) chk("stall_hold", o, prev_obs);
        prev_obs = o;
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 5))
            0:       begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            2:       e = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        res_t o;
        n_vec = 0;
        n_err = 0;
        pipe0 = '0;
        pipe1 = '0;
        prev_obs = '0;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.stall    = 1'b0;
        ifc.A        = 32'd0;
        ifc.B        = 32'd0;

        // Reset state before any clock edge
        #1;
        chk("reset_state", get_obs(), 63'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1.0 x 2.0 : first edge after release captures the pair
        step(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("req027_valid", 63'(ifc.out_valid), 63'd1);
        chk("req027_ez", 63'(ifc.Ez_add), 63'd128);
        chk("req027_mant", {ifc.Ma, ifc.Mb}, {24'h80_0000, 24'h80_0000});
        chk("req027_flags", {ifc.Sz, ifc.is_zero, ifc.is_inf, ifc.is_nan}, 63'd0);

        // Smallest normals: negative exponent sum
        step(1'b1, 1'b0, 32'h0080_0000, 32'h0080_0000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("req028_ez", 63'(ifc.Ez_add), 63'h383);
        chk("req028_flags", {ifc.is_zero, ifc.is_inf, ifc.is_nan}, 63'd0);

        // Denormal x -1.0 flushes to zero
        step(1'b1, 1'b0, 32'h0000_0001, 32'hBF80_0000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("req029", {ifc.is_zero, ifc.Sz, ifc.Ez_add, ifc.Ma, ifc.Mb}, {2'b11, 58'd0});

        // inf x -0 is NaN
        step(1'b1, 1'b0, 32'h7F80_0000, 32'h8000_0000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("req030", {ifc.is_nan, ifc.is_inf, ifc.is_zero}, 63'b100);

        // Four-pair stream with a 3-cycle stall after the second
        step(1'b1, 1'b0, 32'h3FC0_0000, 32'h4040_0000);
        step(1'b1, 1'b0, 32'hC100_0000, 32'h3F00_0000);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h7FC0_0000, 32'h7FC0_0000);
        step(1'b1, 1'b0, 32'h4280_0000, 32'hC2C8_0000);
        step(1'b1, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset pulse with two operands in flight
        step(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000);
        step(1'b1, 1'b0, 32'h4080_0000, 32'h4080_0000);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        o = get_obs();
        chk("req032_async_clear", o, 63'd0);
        pipe0 = '0;
        pipe1 = '0;
        prev_obs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.in_valid = 1'b0;
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized run with bubbles and stalls
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), rand_op(), rand_op());
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
